// File: rtl/rv_div_pkg.sv
// Shared definitions for the RV64 M-extension divider and decoder.
package rv_div_pkg;
  localparam int DIV_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;
endpackage

// File: rtl/rv_div_step.sv
// One restoring division iteration: shift {rem,quo} left, trial-subtract
// the divisor, keep the difference and set the quotient bit when no borrow.
module rv_div_step #(
  parameter int W = 64
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);
  logic [W+1:0] w_shift;
  logic [W+1:0] w_diff;
  logic         w_ok;

  assign w_shift = {rem_i, quo_i[W-1]};
  assign w_diff  = w_shift - {2'b00, dvs_i};
  // Top bit of the difference is the borrow of the trial subtract.
  assign w_ok    = ~w_diff[W+1];
  assign rem_o   = w_ok ? w_diff[W:0] : (W+1)'(w_shift);
  assign quo_o   = {quo_i[W-2:0], w_ok};
endmodule

// File: rtl/rv_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient
// bit per cycle, with RISC-V divide-by-zero and signed-overflow results.
module rv_div
  import rv_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            div_start_i,
  input  logic [XLEN-1:0] div_op1_i,
  input  logic [XLEN-1:0] div_op2_i,
  input  logic            div_signed_i,
  input  logic            div_rem_i,
  output logic            div_busy_o,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_result_o
);
  localparam int CW = $clog2(XLEN + 1);

  div_state_e      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo, r_dvs, r_op1, r_result;
  logic            r_neg_q, r_neg_r, r_rem_sel, r_dz, r_ovf;

  logic            w_op1_neg, w_op2_neg, w_dz, w_ovf;
  logic [XLEN-1:0] w_abs1, w_abs2;
  logic [XLEN:0]   w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt, w_q, w_r, w_fix;

  // Magnitudes are only taken in signed mode with the sign bit set.
  assign w_op1_neg = div_signed_i & div_op1_i[XLEN-1];
  assign w_op2_neg = div_signed_i & div_op2_i[XLEN-1];
  assign w_abs1    = w_op1_neg ? -div_op1_i : div_op1_i;
  assign w_abs2    = w_op2_neg ? -div_op2_i : div_op2_i;
  assign w_dz      = (div_op2_i == '0);
  assign w_ovf     = div_signed_i & (div_op1_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (&div_op2_i);

  rv_div_step #(.W(XLEN)) u_step (
    .rem_i (r_rem),
    .quo_i (r_quo),
    .dvs_i (r_dvs),
    .rem_o (w_rem_nxt),
    .quo_o (w_quo_nxt)
  );

  // Final sign correction and special-case substitution.
  assign w_q   = r_dz  ? '1    :
                 r_ovf ? r_op1 :
                 (r_neg_q ? -r_quo : r_quo);
  assign w_r   = r_dz  ? r_op1 :
                 r_ovf ? '0    :
                 (r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0]);
  assign w_fix = r_rem_sel ? w_r : w_q;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    div_busy_o  = 1'b1;
    div_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        div_busy_o = 1'b0;
        if (div_start_i) w_state_nxt = (w_dz | w_ovf) ? ST_FIXUP : ST_CALC;
      end
      ST_CALC:  if (r_cnt == CW'(1)) w_state_nxt = ST_FIXUP;
      ST_FIXUP: w_state_nxt = ST_DONE;
      ST_DONE: begin
        div_valid_o = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_op1     <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (div_start_i) begin
          r_cnt     <= CW'(XLEN);
          r_rem     <= '0;
          r_quo     <= w_abs1;
          r_dvs     <= w_abs2;
          r_op1     <= div_op1_i;
          r_neg_q   <= div_signed_i & (div_op1_i[XLEN-1] ^ div_op2_i[XLEN-1]);
          r_neg_r   <= w_op1_neg;
          r_rem_sel <= div_rem_i;
          r_dz      <= w_dz;
          r_ovf     <= w_ovf;
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_FIXUP: r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign div_result_o = r_result;
endmodule

// File: tb/tb_rv_div.sv
// Self-checking bench for rv_div: directed table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_rv_div;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        div_start_i = 1'b0;
  logic [63:0] div_op1_i = '0, div_op2_i = '0;
  logic        div_signed_i = 1'b0, div_rem_i = 1'b0;
  logic        div_busy_o, div_valid_o;
  logic [63:0] div_result_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv_div dut (
    .clk          (clk),
    .rstn         (rstn),
    .div_start_i  (div_start_i),
    .div_op1_i    (div_op1_i),
    .div_op2_i    (div_op2_i),
    .div_signed_i (div_signed_i),
    .div_rem_i    (div_rem_i),
    .div_busy_o   (div_busy_o),
    .div_valid_o  (div_valid_o),
    .div_result_o (div_result_o)
  );

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic        r;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  // RISC-V division semantics from plain arithmetic.
  function automatic logic [63:0] ref_div(logic [63:0] a, logic [63:0] b,
                                          logic s, logic r);
    logic [63:0] q, m;
    if (b == 0) begin
      q = ONES; m = a;
    end else if (s && a == MIN64 && b == ONES) begin
      q = a; m = '0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      m = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      m = a % b;
    end
    return r ? m : q;
  endfunction

  function automatic int ref_lat(logic [63:0] a, logic [63:0] b, logic s);
    if (b == 0 || (s && a == MIN64 && b == ONES)) return 2;
    return 66;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h want 0x%016h", name, act, exp);
  endtask

  // Drive a request for one edge, then scramble the operand inputs so the
  // DUT must rely on its latched copies.
  task automatic issue(logic [63:0] a, logic [63:0] b, logic s, logic r);
    div_op1_i = a; div_op2_i = b; div_signed_i = s; div_rem_i = r;
    div_start_i = 1'b1;
    @(posedge clk); #1;
    div_start_i = 1'b0;
    div_op1_i = {$urandom, $urandom};
    div_op2_i = {$urandom, $urandom};
    div_signed_i = 1'($urandom);
    div_rem_i = 1'($urandom);
  endtask

  // Count edges until valid; lat0 is the number of edges already elapsed.
  task automatic wait_valid(int lat0, output logic [63:0] res, output int lat,
                            output int busy_low);
    lat = lat0;
    busy_low = 0;
    while (!div_valid_o && lat < 200) begin
      if (!div_busy_o) busy_low++;
      @(posedge clk); #1;
      lat++;
    end
    if (!div_valid_o) begin
      n_chk++;
      $display("FAIL timeout: no valid after %0d edges", lat);
    end
    if (!div_busy_o) busy_low++;
    res = div_result_o;
  endtask

  vec_t        tbl[12];
  logic [63:0] res, a, b, exp;
  logic        s, r;
  int          lat, bl;

  initial begin
    tbl[0]  = '{"divu100_7",  64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 66};
    tbl[1]  = '{"remu100_7",  64'd100, 64'd7, 1'b0, 1'b1, 64'd2, 66};
    tbl[2]  = '{"div-7_2",    -64'sd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    tbl[3]  = '{"rem-7_2",    -64'sd7, 64'd2, 1'b1, 1'b1, ONES, 66};
    tbl[4]  = '{"rem7_-2",    64'd7, -64'sd2, 1'b1, 1'b1, 64'd1, 66};
    tbl[5]  = '{"divu5_0",    64'd5, 64'd0, 1'b0, 1'b0, ONES, 2};
    tbl[6]  = '{"remu5_0",    64'd5, 64'd0, 1'b0, 1'b1, 64'd5, 2};
    tbl[7]  = '{"div_ovf",    MIN64, ONES, 1'b1, 1'b0, MIN64, 2};
    tbl[8]  = '{"rem_ovf",    MIN64, ONES, 1'b1, 1'b1, 64'd0, 2};
    tbl[9]  = '{"rem-5_0",    -64'sd5, 64'd0, 1'b1, 1'b1, -64'sd5, 2};
    tbl[10] = '{"divu_min_-1", MIN64, ONES, 1'b0, 1'b0, 64'd0, 66};
    tbl[11] = '{"divu_max_1", ONES, 64'd1, 1'b0, 1'b0, ONES, 66};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, div_busy_o}, 64'd0);
    check("rst_valid", {63'd0, div_valid_o}, 64'd0);
    check("rst_result", div_result_o, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].r);
      check({tbl[i].name, "_busy_acc"}, {63'd0, div_busy_o}, 64'd1);
      wait_valid(1, res, lat, bl);
      check({tbl[i].name, "_res"}, res, tbl[i].exp);
      check({tbl[i].name, "_lat"}, 64'(lat), 64'(tbl[i].lat));
      check({tbl[i].name, "_busy_low"}, 64'(bl), 64'd0);
      @(posedge clk); #1;
      check({tbl[i].name, "_pulse"}, {62'd0, div_busy_o, div_valid_o}, 64'd0);
    end

    // Start pulse during a busy divide is ignored.
    issue(64'd1000, 64'd3, 1'b0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    div_op1_i = 64'd50; div_op2_i = 64'd5; div_start_i = 1'b1;
    @(posedge clk); #1;
    div_start_i = 1'b0;
    wait_valid(11, res, lat, bl);
    check("busy_ign_res", res, 64'd333);
    check("busy_ign_lat", 64'(lat), 64'd66);

    // Start held during DONE is ignored; taken in the following IDLE cycle.
    div_op1_i = 64'd100; div_op2_i = 64'd7; div_signed_i = 1'b0;
    div_rem_i = 1'b0; div_start_i = 1'b1;
    @(posedge clk); #1;
    check("done_ign_busy", {62'd0, div_busy_o, div_valid_o}, 64'd0);
    @(posedge clk); #1;
    div_start_i = 1'b0;
    check("b2b_acc_busy", {63'd0, div_busy_o}, 64'd1);
    wait_valid(1, res, lat, bl);
    check("b2b_res", res, 64'd14);
    check("b2b_lat", 64'(lat), 64'd66);
    @(posedge clk); #1;

    // Reset in the middle of a divide aborts it.
    issue(64'd123456789, 64'd11, 1'b0, 1'b0);
    repeat (29) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    check("mrst_busy", {63'd0, div_busy_o}, 64'd0);
    check("mrst_valid", {63'd0, div_valid_o}, 64'd0);
    check("mrst_result", div_result_o, 64'd0);
    bl = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_valid_o || div_busy_o) bl++;
    end
    check("mrst_quiet", 64'(bl), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    issue(ONES, 64'd1, 1'b0, 1'b0);
    wait_valid(1, res, lat, bl);
    check("post_rst_res", res, ONES);
    check("post_rst_lat", 64'(lat), 64'd66);
    @(posedge clk); #1;

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       b = {$urandom, $urandom};
        1:       b = 64'($urandom_range(1, 15));
        2:       b = -64'($urandom_range(1, 15));
        3:       b = {32'd0, $urandom};
        4:       begin a = MIN64; b = ($urandom_range(0, 1) != 0) ? ONES : 64'd0; end
        default: b = 64'd0;
      endcase
      s = 1'($urandom);
      r = 1'($urandom);
      exp = ref_div(a, b, s, r);
      issue(a, b, s, r);
      wait_valid(1, res, lat, bl);
      check($sformatf("rnd%0d_res", k), res, exp);
      check($sformatf("rnd%0d_lat", k), 64'(lat), 64'(ref_lat(a, b, s)));
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rv_div.md
Name: rv_div

Overview:
- Iterative radix-2 restoring integer divider for the RV64 M-extension execute stage. It is the inverse companion of the pipelined multiplier.
- Computes DIV/DIVU/REM/REMU on 64-bit operands, one quotient bit per cycle.
- Uses a start/busy/valid handshake so the pipeline can stall while a divide is in flight.
- Implements RISC-V special-case semantics: divide-by-zero and signed overflow.

Parameters:
XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
div_start_i  input  1  request; accepted only when div_busy_o=0
div_op1_i  input  XLEN  dividend
div_op2_i  input  XLEN  divisor
div_signed_i  input  1  1=signed (DIV/REM), 0=unsigned
div_rem_i  input  1  1=return remainder, 0=return quotient
div_busy_o  output  1  high from accept edge until the cycle valid is asserted (inclusive)
div_valid_o  output  1  one-cycle pulse, result ready
div_result_o  output  XLEN  result; holds value until next valid

Behaviour:
- Reset (async, rstn=0): state=IDLE, div_busy_o=0, div_valid_o=0, div_result_o=0, counter=0, internal regs=0. Reset mid-operation aborts the divide; no valid is produced.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - div_start_i=1 at an edge latches operands, div_signed_i and div_rem_i.
  - Latches |op1| and |op2|; abs is taken only when signed and MSB=1.
  - Latches neg_q = signed & (op1[XLEN-1]^op2[XLEN-1]) and neg_r = signed & op1[XLEN-1].
  - Loads counter=XLEN, partial remainder=0.
  - Next state: CALC normally. Goes to FIXUP directly if divisor==0 or signed overflow (op1=-2^(XLEN-1), op2=-1).
- CALC: each cycle:
  - Shift {rem,quo} left 1.
  - Trial subtract divisor from rem; if non-negative, keep the difference and set quo[0]=1.
  - Decrement counter; when counter reaches 1 on this edge, go to FIXUP. CALC spends exactly XLEN cycles.
- FIXUP (1 cycle): select the final value into div_result_o.
  - Normal: q = neg_q ? -quo : quo; r = neg_r ? -rem : rem.
  - Divide-by-zero: q = all ones; r = op1 (original, unsigned view).
  - Signed overflow: q = op1 (-2^(XLEN-1)); r = 0.
  - Output = div_rem_i ? r : q. Next state: DONE.
- DONE (1 cycle): div_valid_o=1, div_busy_o=1; next state IDLE. div_busy_o drops the following cycle.
- Latency, counted in edges from the edge sampling div_start_i to the edge after which div_valid_o is high:
  - Normal: XLEN+2 (66).
  - Special cases: 2.
- div_start_i while busy (including DONE) is ignored, not queued. Back-to-back start is accepted in the first IDLE cycle after DONE.
- Operand inputs need only be stable on the accept edge.
- Arithmetic: internal remainder is XLEN+1 bits so the trial-subtract borrow is visible. Negation is two's complement modulo 2^XLEN.
- Unsigned mode never negates; the special-case table uses the same encodings.

Decomposition:
- rv_div_pkg: XLEN default and the state enum (IDLE/CALC/FIXUP/DONE); shared with the M-extension decoder.
- One sub-module, rv_div_step: combinational single restoring iteration (in rem, quo, divisor; out rem_next, quo_next). It is kept separate so a radix-4 variant can instantiate two in series later.

Test Plan:
- DIVU 100/7, then REMU 100/7 → 14 (0x0E) and 2; div_valid_o asserts exactly 66 edges after accept; div_busy_o high throughout.
- DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF (-1); REM 7/-2 → 1.
- DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF; REMU 5/0 → 5; valid 2 edges after accept.
- DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000; REM → 0; latency 2.
- Pulse div_start_i with new operands at cycle 10 of a busy divide → ignored; the first result is unchanged. A start in the cycle after valid is accepted.
- Assert rstn=0 at cycle 30 of a divide → all outputs 0 immediately, no valid pulse. After release, a new DIVU 0xFFFF_FFFF_FFFF_FFFF/1 → 0xFFFF_FFFF_FFFF_FFFF.
